// File: rtl/fifo_hw_serializer.sv
// Drains halfwords from an FWFT FIFO and sends each LSB-first as a UART-style frame:
// one start bit, DATA_WIDTH data bits, one stop bit, each held CLKS_PER_BIT clocks.
module fifo_hw_serializer #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  tx_q, tx_d;
  logic                  rd_q, rd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  last_clk;

  assign last_clk = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        // FWFT head is captured on the same edge that issues the pop strobe
        if (en && !fifo_empty) begin
          shift_d = fifo_rd_data;
          state_d = StStart;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          rd_d    = 1'b1;
        end
      end
      StStart: begin
        if (last_clk) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StData;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (last_clk) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IdxW'(DATA_WIDTH - 1)) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + IdxW'(1);
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        // Registered pulse lands on the final stop-bit cycle
        done_d = (cnt_q == CntW'(CLKS_PER_BIT - 2));
        if (last_clk) begin
          cnt_d   = '0;
          state_d = StIdle;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_rd    = rd_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_hw_serializer.sv
// Bench for fifo_hw_serializer: frame-position reference model with a queue-based FIFO,
// table-driven frame vectors, directed corner sequences and a randomized soak.
module tb_fifo_hw_serializer;

  localparam int CPB = 4;
  localparam int DW  = 16;
  localparam int F   = (DW + 2) * CPB;

  logic          clk = 1'b0;
  logic          rst, en, fifo_empty, fifo_rd, tx, busy, frame_done;
  logic [DW-1:0] fifo_rd_data;

  fifo_hw_serializer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd      (fifo_rd),
    .tx           (tx),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [15:0] bits;  // serial data bits, first-sent in the MSB
  } vec_t;

  int            tests = 0;
  int            fails = 0;
  int            cyc   = 0;
  int            pos   = 0;  // 0 = idle, 1..F = cycle within frame
  logic [15:0]   mword = '0;
  bit            force_empty = 0;
  logic [15:0]   fq[$];
  int            rd_times[$];
  logic          tx_hist[int];
  logic          busy_hist[int];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic exp_tx(input int p, input logic [15:0] w);
    int b;
    if (p == 0) return 1'b1;
    if (p <= CPB) return 1'b0;
    b = (p - 1) / CPB - 1;
    if (b < DW) return w[b];
    return 1'b1;
  endfunction

  task automatic drive_fifo();
    fifo_empty   = force_empty || (fq.size() == 0);
    fifo_rd_data = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [15:0] w);
    fq.push_back(w);
    drive_fifo();
  endtask

  task automatic tick();
    int          pos_n;
    logic [15:0] word_n;
    logic        rd_pre;
    pos_n  = pos;
    word_n = mword;
    if (rst) pos_n = 0;
    else if (pos == 0) begin
      if (en && !fifo_empty) begin
        pos_n  = 1;
        word_n = fifo_rd_data;
      end
    end else if (pos == F) pos_n = 0;
    else pos_n = pos + 1;
    rd_pre = fifo_rd;
    @(posedge clk);
    #1;
    pos   = pos_n;
    mword = word_n;
    cyc++;
    if (rd_pre === 1'b1 && fq.size() != 0) void'(fq.pop_front());
    drive_fifo();
    if (fifo_rd === 1'b1) rd_times.push_back(cyc);
    tx_hist[cyc]   = tx;
    busy_hist[cyc] = busy;
  endtask

  task automatic check_model();
    cmp("model{tx,busy,rd,done}", {28'd0, tx, busy, fifo_rd, frame_done},
        {28'd0, exp_tx(pos, mword), pos != 0, pos == 1, pos == F});
  endtask

  task automatic run_frame(input int n, input logic [15:0] bits, input int drop_at,
                           output int busy_cnt, output int done_at);
    int b;
    busy_cnt = 0;
    done_at  = -1;
    for (int i = 0; i < n; i++) begin
      tick();
      check_model();
      if (busy === 1'b1) busy_cnt++;
      if (frame_done === 1'b1) done_at = busy_cnt;
      if (pos > CPB && pos <= CPB * (DW + 1) && ((pos - 1) % CPB) == 0) begin
        b = (pos - 1) / CPB - 1;
        cmp($sformatf("tbl_bit%0d", b), {31'd0, tx}, {31'd0, bits[15-b]});
      end
      if (pos == drop_at) begin
        en          = 1'b0;
        force_empty = 1;
        drive_fifo();
      end
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   bc, da, n0;

    vecs[0] = '{word: 16'hA5C3, bits: 16'b1100_0011_1010_0101};
    vecs[1] = '{word: 16'h0001, bits: 16'b1000_0000_0000_0000};
    vecs[2] = '{word: 16'h8000, bits: 16'b0000_0000_0000_0001};
    vecs[3] = '{word: 16'h1234, bits: 16'b0010_1100_0100_1000};
    vecs[4] = '{word: 16'hFFFF, bits: 16'b1111_1111_1111_1111};
    vecs[5] = '{word: 16'h0F0F, bits: 16'b1111_0000_1111_0000};

    rst = 1'b1;
    en  = 1'b0;
    drive_fifo();
    tick();
    tick();
    cmp("reset_tx", {31'd0, tx}, 32'd1);
    cmp("reset_busy", {31'd0, busy}, 32'd0);
    cmp("reset_rd", {31'd0, fifo_rd}, 32'd0);
    cmp("reset_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;

    // Idle with empty FIFO
    en = 1'b1;
    rd_times.delete();
    for (int i = 0; i < 50; i++) begin
      tick();
      check_model();
    end
    cmp("idle_rd_count", rd_times.size(), 0);

    // Table-driven single frames
    foreach (vecs[k]) begin
      rd_times.delete();
      push(vecs[k].word);
      en = 1'b1;
      run_frame(F + 2, vecs[k].bits, -1, bc, da);
      cmp($sformatf("busy_len_%04h", vecs[k].word), bc, F);
      cmp($sformatf("done_at_%04h", vecs[k].word), da, F);
      cmp($sformatf("rd_count_%04h", vecs[k].word), rd_times.size(), 1);
    end

    // Back-to-back frames
    rd_times.delete();
    push(16'h0001);
    push(16'h8000);
    for (int i = 0; i < 2 * F + 10; i++) begin
      tick();
      check_model();
    end
    cmp("b2b_rd_count", rd_times.size(), 2);
    if (rd_times.size() == 2) begin
      cmp("b2b_rd_spacing", rd_times[1] - rd_times[0], F + 1);
      cmp("b2b_gap_idle", {30'd0, tx_hist[rd_times[1] - 1], busy_hist[rd_times[1] - 1]}, 32'd2);
      cmp("b2b_last_bit", {31'd0, tx_hist[rd_times[1] + CPB * DW]}, 32'd1);
    end

    // en held low with data waiting
    rd_times.delete();
    en = 1'b0;
    push(16'h5A5A);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_model();
      cmp("en0_tx", {31'd0, tx}, 32'd1);
    end
    cmp("en0_rd_count", rd_times.size(), 0);
    en = 1'b1;
    tick();
    check_model();
    cmp("en1_start_rd", {31'd0, fifo_rd}, 32'd1);
    cmp("en1_start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < F + 2; i++) begin
      tick();
      check_model();
    end

    // en dropped and FIFO shown empty mid-frame
    rd_times.delete();
    push(16'h1234);
    push(16'h7777);
    en = 1'b1;
    run_frame(F + 20, vecs[3].bits, 30, bc, da);
    cmp("drop_busy_len", bc, F);
    cmp("drop_done_at", da, F);
    cmp("drop_rd_count", rd_times.size(), 1);
    force_empty = 0;
    fq.delete();
    drive_fifo();

    // Reset mid-frame discards the popped word
    rd_times.delete();
    push(16'hBEEF);
    push(16'h0F0F);
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      check_model();
    end
    rst = 1'b1;
    tick();
    check_model();
    cmp("rst_mid_tx", {31'd0, tx}, 32'd1);
    cmp("rst_mid_busy", {31'd0, busy}, 32'd0);
    cmp("rst_mid_rd", {31'd0, fifo_rd}, 32'd0);
    rst = 1'b0;
    run_frame(F + 2, vecs[5].bits, -1, bc, da);
    cmp("rst_next_busy_len", bc, F);
    cmp("rst_rd_count", rd_times.size(), 2);

    // Randomized soak against the model
    n0 = tests;
    for (int i = 0; i < 4000; i++) begin
      en  = ($urandom_range(9) != 0);
      rst = ($urandom_range(399) == 0);
      if ($urandom_range(3) == 0 && fq.size() < 8) push(16'($urandom));
      tick();
      check_model();
    end
    rst = 1'b0;
    cmp("random_checks_ran", (tests - n0 >= 4000) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
